reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order retirement buffer for the out-of-order core, sitting between dispatch (upstream, which fills `rob_t`/`dispatch_reservation_t` with a `rob_id`) and the CDB/commit side (downstream of the functional units producing `cdb_t`). Allocates one entry per dispatched instruction and returns its `rob_id`. Marks entries done on CDB broadcasts. Retires the head in program order, handing the architectural/physical register mapping to the RRAT and free list.

## Interface
- `ROB_DEPTH`, 16: number of entries; power of two, 4..128.
- `FU_COUNT`, package value (2): number of CDB writeback ports.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `dispatch_valid` in 1: dispatch presents an instruction.
- `dispatch_ready` out 1: entry available; transfer when valid && ready.
- `dispatch_rd_arch` in 5: architectural destination.
- `dispatch_rd_phys` in 6: newly allocated physical destination.
- `dispatch_rd_old` in 6: previous mapping of rd, freed at commit.
- `dispatch_rob_id` out 8: id assigned to the current dispatch (tail index, zero-extended).
- `cdb_valid` in FU_COUNT: per-port writeback strobe.
- `cdb_rob_id` in FU_COUNT×8: per-port completing id.
- `commit_valid` out 1: head entry is retiring this cycle.
- `commit_rob_id` out 8: id of the retiring entry.
- `commit_rd_arch` out 5, `commit_rd_phys` out 6, `commit_rd_old` out 6: mapping of the retiring entry.
- `commit_rd_we` out 1: `commit_valid && commit_rd_arch != 0`.
- `count` out $clog2(ROB_DEPTH)+1: occupied entries.

## Operation
- Storage per entry: `valid`, `done`, `rd_arch`, `rd_phys`, `rd_old`.
- Pointers `head` and `tail` are $clog2(ROB_DEPTH)+1 bits wide, where the MSB is the wrap bit.
- Empty when head == tail. Full when the index bits are equal and the wrap bits differ.
- `dispatch_ready = !full`. It is computed from the registered state only, so a same-cycle commit does not free a slot for dispatch.
- On dispatch: write the entry at tail[index] with valid=1 and done=0, then increment tail.
- `dispatch_rob_id` equals tail[index] regardless of `dispatch_valid`.
- On a writeback, each port i with `cdb_valid[i]` sets `done` at `cdb_rob_id[i]` if that entry is valid.
  - Ignored if the id ≥ ROB_DEPTH or the entry is invalid.
  - Multiple ports hitting the same id is legal; the result is done=1.
- `commit_valid = !empty && entry[head].valid && entry[head].done`. This is combinational from the registers.
- The consumer always accepts a commit. On `commit_valid`, clear entry[head].valid and increment head.
- At most one commit per cycle.
- Commit outputs are driven from entry[head] whenever not empty; they are meaningful only with `commit_valid`.
- `count = tail − head`, computed modulo 2^(index+1).

## Timing
- Reset (async, `rst_n`=0):
  - head=tail=0; all valid and done bits 0.
  - Outputs: `dispatch_ready`=1, `dispatch_rob_id`=0, `commit_valid`=0, `commit_rd_we`=0, `count`=0.
  - The remaining commit outputs reflect entry 0 and are don't-care.
- Reset mid-operation discards all entries immediately, with no commit pulses.
- Dispatch-to-ready latency: an entry dispatched in cycle N can receive a CDB write in cycle N+1, and can commit at the earliest in cycle N+2.
- A writeback in the same cycle as the entry's dispatch is illegal and is not required to be captured.
- Writeback in cycle N makes `commit_valid` visible in cycle N+1; there is no same-cycle bypass.
- Simultaneous dispatch and commit:
  - Both pointers advance.
  - `count` is unchanged.
- Wrap-around: indices roll from ROB_DEPTH−1 to 0 and the wrap bit toggles. Behaviour is otherwise identical.

## Structure
- Add to `rv32i_types`:
  - `ROB_DEPTH`.
  - `typedef rob_entry_t` (valid, done, rd_arch, rd_phys, rd_old).
  - `typedef logic [7:0] rob_id_t`, replacing the hardcoded 8-bit `rob_id`/`rs*_source` fields in `rob_t`.
- Single module, no sub-modules. The circular-pointer logic is inline; a generic FIFO is not reused because done-marking needs random-access writes.

## Test plan
- Reset: assert `rst_n`=0 mid-run with 5 entries → `count`=0, `dispatch_ready`=1, `commit_valid`=0 immediately; the next dispatch gets `dispatch_rob_id`=0.
- Single flow:
  - Dispatch rd_arch=3, rd_phys=40, rd_old=3; the assigned id is 0.
  - CDB port 0 writes id 0 in the next cycle.
  - Result: the cycle after that shows `commit_valid`=1, `commit_rd_arch`=3, `commit_rd_phys`=40, `commit_rd_old`=3, `commit_rd_we`=1.
- Out-of-order completion:
  - Dispatch ids 0,1,2; CDB completes 2, then 1; no commit occurs.
  - CDB completes 0 → commits 0,1,2 on three consecutive cycles.
- Full and dual-port writeback:
  - 16 dispatches → `dispatch_ready`=0 and `count`=16; a 17th dispatch_valid is not accepted.
  - Both CDB ports write ids 0 and 1 in the same cycle → the next two cycles commit them; ready returns after the first commit.
- Wrap-around: run 40 instructions continuously with a 2-cycle completion delay → ids wrap 15→0, commit order matches dispatch order, and `count` never exceeds 16.
- x0 and bogus writebacks:
  - Dispatch rd_arch=0 → commits with `commit_rd_we`=0.
  - CDB writes to id 20 and to an empty entry → no state change.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the out-of-order core's reorder buffer and the
// structures that carry ROB ids between dispatch, reservation stations and the CDB.
package reorder_buffer_pkg;

    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned FU_COUNT  = 2;
    localparam int unsigned ROB_ID_W  = 8;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [4:0]          arch_reg_t;
    typedef logic [5:0]          phys_reg_t;

    // One ROB slot: liveness, completion and the rename mapping handed to commit.
    typedef struct packed {
        logic      valid;
        logic      done;
        arch_reg_t rd_arch;
        phys_reg_t rd_phys;
        phys_reg_t rd_old;
    } rob_entry_t;

    // Instruction as seen by dispatch once it has been assigned a ROB slot.
    typedef struct packed {
        rob_id_t     rob_id;
        logic [31:0] pc;
        arch_reg_t   rd_arch;
        phys_reg_t   rd_phys;
        phys_reg_t   rd_old;
        rob_id_t     rs1_source;
        rob_id_t     rs2_source;
    } rob_t;

    // Reservation-station payload; sources name the producing ROB entry.
    typedef struct packed {
        logic      valid;
        rob_id_t   rob_id;
        phys_reg_t rs1_phys;
        logic      rs1_ready;
        rob_id_t   rs1_source;
        phys_reg_t rs2_phys;
        logic      rs2_ready;
        rob_id_t   rs2_source;
        phys_reg_t rd_phys;
    } dispatch_reservation_t;

    // Common data bus broadcast from a functional unit.
    typedef struct packed {
        logic        valid;
        rob_id_t     rob_id;
        phys_reg_t   rd_phys;
        logic [31:0] data;
    } cdb_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates a slot per dispatched instruction,
// marks slots done from CDB writebacks and retires the head in program order.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_DEPTH = reorder_buffer_pkg::ROB_DEPTH,
    parameter int unsigned FU_COUNT  = reorder_buffer_pkg::FU_COUNT
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic                           dispatch_valid,
    output logic                           dispatch_ready,
    input  logic [4:0]                     dispatch_rd_arch,
    input  logic [5:0]                     dispatch_rd_phys,
    input  logic [5:0]                     dispatch_rd_old,
    output logic [7:0]                     dispatch_rob_id,

    input  logic [FU_COUNT-1:0]            cdb_valid,
    input  logic [FU_COUNT*8-1:0]          cdb_rob_id,

    output logic                           commit_valid,
    output logic [7:0]                     commit_rob_id,
    output logic [4:0]                     commit_rd_arch,
    output logic [5:0]                     commit_rd_phys,
    output logic [5:0]                     commit_rd_old,
    output logic                           commit_rd_we,

    output logic [$clog2(ROB_DEPTH):0]     count
);

    localparam int unsigned IDX_W = $clog2(ROB_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    rob_entry_t       entries_q [ROB_DEPTH];
    rob_entry_t       entries_d [ROB_DEPTH];

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             empty;
    logic             full;
    logic             dispatch_fire;
    logic             commit_fire;
    rob_entry_t       head_entry;

    logic [IDX_W-1:0] cdb_idx      [FU_COUNT];
    logic             cdb_hit      [FU_COUNT];

    // Occupancy and handshake status, derived from registered state only.
    always_comb begin
        head_idx      = head_q[IDX_W-1:0];
        tail_idx      = tail_q[IDX_W-1:0];
        empty         = (head_q == tail_q);
        full          = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
        head_entry    = entries_q[head_idx];
        dispatch_fire = dispatch_valid && !full;
        commit_fire   = !empty && head_entry.valid && head_entry.done;
    end

    // Decode each CDB port; out-of-range ids and empty slots are dropped.
    always_comb begin
        for (int i = 0; i < int'(FU_COUNT); i++) begin
            logic [7:0] id;
            id         = cdb_rob_id[i*8 +: 8];
            cdb_idx[i] = id[IDX_W-1:0];
            cdb_hit[i] = cdb_valid[i] && (32'(id) < ROB_DEPTH) && entries_q[id[IDX_W-1:0]].valid;
        end
    end

    // Next-state: writebacks, then allocation at tail, then retirement at head.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;

        for (int i = 0; i < int'(FU_COUNT); i++) begin
            if (cdb_hit[i]) begin
                entries_d[cdb_idx[i]].done = 1'b1;
            end
        end

        // Tail slot is never live when not full, so no conflict with writebacks.
        if (dispatch_fire) begin
            entries_d[tail_idx].valid   = 1'b1;
            entries_d[tail_idx].done    = 1'b0;
            entries_d[tail_idx].rd_arch = dispatch_rd_arch;
            entries_d[tail_idx].rd_phys = dispatch_rd_phys;
            entries_d[tail_idx].rd_old  = dispatch_rd_old;
            tail_d                      = tail_q + PTR_W'(1);
        end

        if (commit_fire) begin
            entries_d[head_idx].valid = 1'b0;
            entries_d[head_idx].done  = 1'b0;
            head_d                    = head_q + PTR_W'(1);
        end
    end

    // State registers; reset discards every entry at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < int'(ROB_DEPTH); i++) begin
                entries_q[i] <= entries_d[i];
            end
        end
    end

    // Outputs; commit fields follow the head slot and only matter with commit_valid.
    always_comb begin
        dispatch_ready  = !full;
        dispatch_rob_id = rob_id_t'(tail_idx);
        commit_valid    = commit_fire;
        commit_rob_id   = rob_id_t'(head_idx);
        commit_rd_arch  = head_entry.rd_arch;
        commit_rd_phys  = head_entry.rd_phys;
        commit_rd_old   = head_entry.rd_old;
        commit_rd_we    = commit_fire && (head_entry.rd_arch != '0);
        count           = tail_q - head_q;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: dispatches push expected retirements,
// a negedge monitor pops and compares each commit the DUT presents.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;
    localparam int FUS   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            dispatch_valid;
    logic            dispatch_ready;
    logic [4:0]      dispatch_rd_arch;
    logic [5:0]      dispatch_rd_phys;
    logic [5:0]      dispatch_rd_old;
    logic [7:0]      dispatch_rob_id;
    logic [FUS-1:0]  cdb_valid;
    logic [FUS*8-1:0] cdb_rob_id;
    logic            commit_valid;
    logic [7:0]      commit_rob_id;
    logic [4:0]      commit_rd_arch;
    logic [5:0]      commit_rd_phys;
    logic [5:0]      commit_rd_old;
    logic            commit_rd_we;
    logic [4:0]      count;

    typedef struct packed {
        logic [7:0] id;
        logic [4:0] arch;
        logic [5:0] phys;
        logic [5:0] old;
        logic       we;
    } exp_t;

    exp_t exp_q[$];
    int   exp_tail;
    int   n_checks = 0;
    int   n_errors = 0;
    int   disp_id [40];

    reorder_buffer #(
        .ROB_DEPTH (DEPTH),
        .FU_COUNT  (FUS)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dispatch_valid   (dispatch_valid),
        .dispatch_ready   (dispatch_ready),
        .dispatch_rd_arch (dispatch_rd_arch),
        .dispatch_rd_phys (dispatch_rd_phys),
        .dispatch_rd_old  (dispatch_rd_old),
        .dispatch_rob_id  (dispatch_rob_id),
        .cdb_valid        (cdb_valid),
        .cdb_rob_id       (cdb_rob_id),
        .commit_valid     (commit_valid),
        .commit_rob_id    (commit_rob_id),
        .commit_rd_arch   (commit_rd_arch),
        .commit_rd_phys   (commit_rd_phys),
        .commit_rd_old    (commit_rd_old),
        .commit_rd_we     (commit_rd_we),
        .count            (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every presented commit must match the oldest outstanding dispatch.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (rst_n) begin
            if (commit_valid) begin
                got = {commit_rob_id, commit_rd_arch, commit_rd_phys, commit_rd_old, commit_rd_we};
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_commit: got id %0d, expected no commit", commit_rob_id);
                end else begin
                    e = exp_q.pop_front();
                    check("commit_entry", 32'(got), 32'(e));
                end
            end else begin
                check("idle_rd_we", 32'(commit_rd_we), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        dispatch_valid = 1'b0;
        cdb_valid      = '0;
    endtask

    task automatic drive_dispatch(input logic [4:0] arch, input logic [5:0] phys,
                                  input logic [5:0] old);
        exp_t e;
        dispatch_valid   = 1'b1;
        dispatch_rd_arch = arch;
        dispatch_rd_phys = phys;
        dispatch_rd_old  = old;
        check("dispatch_ready", 32'(dispatch_ready), 32'd1);
        check("dispatch_id", 32'(dispatch_rob_id), 32'(exp_tail % DEPTH));
        e.id   = 8'(exp_tail % DEPTH);
        e.arch = arch;
        e.phys = phys;
        e.old  = old;
        e.we   = (arch != 5'd0);
        exp_q.push_back(e);
        exp_tail++;
    endtask

    task automatic set_cdb(input int port, input int id);
        cdb_valid[port]           = 1'b1;
        cdb_rob_id[port*8 +: 8]   = 8'(id);
    endtask

    task automatic do_reset(input string name);
        rst_n          = 1'b0;
        dispatch_valid = 1'b0;
        cdb_valid      = '0;
        #1;
        check({name, "_count"}, 32'(count), 32'd0);
        check({name, "_ready"}, 32'(dispatch_ready), 32'd1);
        check({name, "_commit"}, 32'(commit_valid), 32'd0);
        check({name, "_id"}, 32'(dispatch_rob_id), 32'd0);
        exp_q.delete();
        exp_tail = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        dispatch_valid   = 1'b0;
        dispatch_rd_arch = '0;
        dispatch_rd_phys = '0;
        dispatch_rd_old  = '0;
        cdb_valid        = '0;
        cdb_rob_id       = '0;
        exp_tail         = 0;

        do_reset("por");

        // Single flow: dispatch, writeback next cycle, commit the cycle after.
        drive_dispatch(5'd3, 6'd40, 6'd3);
        step();
        set_cdb(0, 0);
        check("single_not_done", 32'(commit_valid), 32'd0);
        step();
        check("single_visible", 32'(commit_valid), 32'd1);
        check("single_we", 32'(commit_rd_we), 32'd1);
        check("single_phys", 32'(commit_rd_phys), 32'd40);
        step();
        check("single_count", 32'(count), 32'd0);

        // Out-of-order completion retires in order.
        do_reset("ooo");
        for (int i = 0; i < 3; i++) begin
            drive_dispatch(5'(i + 4), 6'(i + 20), 6'(i + 4));
            step();
        end
        set_cdb(0, 2);
        step();
        set_cdb(1, 1);
        step();
        check("ooo_held", 32'(commit_valid), 32'd0);
        check("ooo_count", 32'(count), 32'd3);
        set_cdb(0, 0);
        step();
        for (int k = 0; k < 3; k++) begin
            check("ooo_commit_valid", 32'(commit_valid), 32'd1);
            check("ooo_commit_id", 32'(commit_rob_id), 32'(k));
            step();
        end
        check("ooo_empty", 32'(count), 32'd0);

        // Fill to capacity, then dual-port writeback of the two oldest.
        do_reset("full");
        for (int i = 0; i < DEPTH; i++) begin
            drive_dispatch(5'(i + 1), 6'(i + 16), 6'(i + 1));
            step();
        end
        check("full_ready", 32'(dispatch_ready), 32'd0);
        check("full_count", 32'(count), 32'd16);
        dispatch_valid   = 1'b1;
        dispatch_rd_arch = 5'd9;
        dispatch_rd_phys = 6'd63;
        dispatch_rd_old  = 6'd9;
        check("full_wrap_id", 32'(dispatch_rob_id), 32'd0);
        step();
        check("full_reject", 32'(count), 32'd16);
        set_cdb(0, 0);
        set_cdb(1, 1);
        step();
        check("dual_commit0", 32'(commit_rob_id), 32'd0);
        check("dual_still_full", 32'(dispatch_ready), 32'd0);
        step();
        check("dual_ready_back", 32'(dispatch_ready), 32'd1);
        check("dual_commit1", 32'(commit_valid), 32'd1);
        step();
        check("dual_count", 32'(count), 32'd14);

        // Reset mid-run with five live entries and a commit pending.
        do_reset("pre_mid");
        for (int i = 0; i < 5; i++) begin
            drive_dispatch(5'(i + 1), 6'(i + 30), 6'(i));
            step();
        end
        check("mid_count_before", 32'(count), 32'd5);
        set_cdb(0, 0);
        step();
        check("mid_pending", 32'(commit_valid), 32'd1);
        do_reset("mid");
        drive_dispatch(5'd5, 6'd9, 6'd2);
        step();
        set_cdb(0, 0);
        step();
        wait_drain("mid_drain", 8);

        // Continuous stream with two-cycle completion; ids wrap twice.
        do_reset("wrap");
        for (int c = 0; c < 42; c++) begin
            if (c < 40) begin
                disp_id[c] = c % DEPTH;
                drive_dispatch(5'(1 + (c % 31)), 6'(c + 8), 6'(c % 32));
            end
            if (c >= 2) begin
                set_cdb(0, disp_id[c-2]);
            end
            check("wrap_count_bound", 32'(count <= 5'd16), 32'd1);
            step();
        end
        wait_drain("wrap_drain", 10);

        // x0 destination and bogus writebacks.
        do_reset("x0");
        drive_dispatch(5'd0, 6'd7, 6'd0);
        step();
        set_cdb(0, 20);
        set_cdb(1, 5);
        step();
        check("bogus_count", 32'(count), 32'd1);
        check("bogus_no_commit", 32'(commit_valid), 32'd0);
        for (int i = 1; i < 6; i++) begin
            drive_dispatch(5'(i + 1), 6'(i + 20), 6'(i));
            step();
        end
        // id 20 aliases slot 4 on the index bits while slot 4 is live
        set_cdb(0, 20);
        set_cdb(1, 0);
        step();
        check("x0_valid", 32'(commit_valid), 32'd1);
        check("x0_we", 32'(commit_rd_we), 32'd0);
        set_cdb(0, 1);
        set_cdb(1, 2);
        step();
        set_cdb(0, 3);
        step();
        step();
        step();
        check("alias_ignored", 32'(commit_valid), 32'd0);
        check("alias_count", 32'(count), 32'd2);
        set_cdb(0, 4);
        set_cdb(1, 4);
        step();
        set_cdb(0, 5);
        step();
        wait_drain("x0_drain", 6);
        check("final_count", 32'(count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
